// File: rtl/tpu_package.sv
// Shared TPU definitions: accumulator geometry, read-controller mode and
// state encodings, and the per-bank address array used by the accumulator
// read path.
package tpu_package;

   localparam int NUM_BANKS = 32;
   localparam int ACC_DEPTH = 128;
   localparam int ACC_AW    = 7;

   // Step counter must reach N + NUM_BANKS - 2 for the largest N.
   localparam int STEP_W = $clog2(ACC_DEPTH + NUM_BANKS) + 1;

   typedef enum logic {
      ACC_RD_NORMAL = 1'b0,
      ACC_RD_DIAG   = 1'b1
   } acc_rd_mode;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } acc_rd_state_t;

   // One row address per bank; bank b occupies bits [b*ACC_AW +: ACC_AW].
   typedef logic [NUM_BANKS-1:0][ACC_AW-1:0] diag_addr_array_t;

   // Final step index of a sequence. DIAG needs NUM_BANKS-1 extra steps so the
   // last bank sees its final row. Only meaningful for n >= 1.
   function automatic logic [STEP_W-1:0] acc_rd_last_step(acc_rd_mode m,
                                                          logic [ACC_AW:0] n);
      if (m == ACC_RD_DIAG)
         return STEP_W'(n) + STEP_W'(NUM_BANKS - 2);
      else
         return STEP_W'(n) - STEP_W'(1);
   endfunction

endpackage

// File: rtl/acc_rd_addr_gen.sv
// Combinational per-bank enable/address generator for accumulator reads.
// NORMAL: every bank reads row base+r. DIAG: bank b reads row base+(r-b) only
// while 0 <= r-b < n, which undoes the diagonal skew of the systolic array.
// Addresses wrap modulo the bank depth.
module acc_rd_addr_gen
   import tpu_package::*;
(
   input  acc_rd_mode              mode,
   input  logic [ACC_AW-1:0]       base,
   input  logic [ACC_AW:0]         n,
   input  logic [STEP_W-1:0]       r,
   output logic [NUM_BANKS-1:0]    en,
   output diag_addr_array_t        addr
);

   // Per-bank enable and row address for step r.
   always_comb begin
      en   = '0;
      addr = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (mode == ACC_RD_NORMAL) begin
            en[b]   = 1'b1;
            addr[b] = base + r[ACC_AW-1:0];
         end else if ((r >= STEP_W'(b)) && ((r - STEP_W'(b)) < STEP_W'(n))) begin
            en[b]   = 1'b1;
            addr[b] = base + (r[ACC_AW-1:0] - ACC_AW'(b));
         end
      end
   end

endmodule

// File: rtl/acc_rd_ctrl.sv
// Accumulator read sequencer. After a tile completes it walks the 32
// accumulator banks row by row (NORMAL) or along the de-skewing diagonal
// (DIAG), honouring out_ready back-pressure, and presents a valid strobe and
// bank mask aligned to the bank read data RD_LAT cycles after issue.
// Optional build macro ACC_RD_CLEAR_EN adds clr_en, a copy of rd_en that
// makes every read also clear its entry (read-first banks).
module acc_rd_ctrl
   import tpu_package::*;
#(
   parameter int NUM_BANKS = 32,
   parameter int ACC_AW    = 7,
   parameter int RD_LAT    = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          mode,
   input  logic [ACC_AW-1:0]             base_addr,
   input  logic [ACC_AW:0]               num_rows,
   input  logic                          out_ready,
   output logic [NUM_BANKS-1:0]          rd_en,
   output logic [NUM_BANKS*ACC_AW-1:0]   rd_addr,
   output logic                          out_valid,
   output logic [NUM_BANKS-1:0]          out_bank_mask,
   output logic                          busy,
   output logic                          done
`ifdef ACC_RD_CLEAR_EN
   ,
   output logic [NUM_BANKS-1:0]          clr_en
`endif
);

   localparam int DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   acc_rd_state_t          state;
   acc_rd_state_t          next_state;
   logic                   accept;
   logic                   issue;

   acc_rd_mode             mode_q;
   logic [ACC_AW-1:0]      base_q;
   logic [ACC_AW:0]        n_q;
   logic [STEP_W-1:0]      last_q;
   logic [STEP_W-1:0]      step;
   logic [DRAIN_W-1:0]     drain_cnt;

   logic [NUM_BANKS-1:0]   gen_en;
   diag_addr_array_t       gen_addr;
   logic [NUM_BANKS-1:0]   mask_pipe [RD_LAT];

   acc_rd_addr_gen u_addr_gen (
      .mode (mode_q),
      .base (base_q),
      .n    (n_q),
      .r    (step),
      .en   (gen_en),
      .addr (gen_addr)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // Next-state logic plus accept/issue strobes. A start during the done
   // pulse is dropped so the new sequence cannot overlap the old handshake.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      issue      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !done) begin
               accept     = 1'b1;
               next_state = (num_rows == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (out_ready) begin
               issue = 1'b1;
               if (step == last_q) next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt == DRAIN_W'(RD_LAT - 1)) next_state = ST_DONE;
         end
         ST_DONE: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Sequence context: parameters latched at start, step counter, drain timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q    <= ACC_RD_NORMAL;
         base_q    <= '0;
         n_q       <= '0;
         last_q    <= '0;
         step      <= '0;
         drain_cnt <= '0;
      end else begin
         if (accept) begin
            mode_q <= acc_rd_mode'(mode);
            base_q <= base_addr;
            n_q    <= num_rows;
            last_q <= acc_rd_last_step(acc_rd_mode'(mode), num_rows);
            step   <= '0;
         end else if (issue) begin
            step <= step + STEP_W'(1);
         end
         if (state == ST_DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
         else                   drain_cnt <= '0;
      end
   end

   // Registered bank strobes; idle cycles drive enables and addresses to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en   <= '0;
         rd_addr <= '0;
      end else if (issue) begin
         rd_en   <= gen_en;
         rd_addr <= gen_addr;
      end else begin
         rd_en   <= '0;
         rd_addr <= '0;
      end
   end

   // Status outputs; done trails the DONE state by a cycle so it lines up one
   // cycle after the last returned row, and busy drops as done rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (next_state != ST_IDLE);
         done <= (state == ST_DONE);
      end
   end

   // Enable pipe matching the bank read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) mask_pipe[i] <= '0;
      end else begin
         mask_pipe[0] <= rd_en;
         for (int i = 1; i < RD_LAT; i++) mask_pipe[i] <= mask_pipe[i-1];
      end
   end

   assign out_bank_mask = mask_pipe[RD_LAT-1];
   assign out_valid     = |mask_pipe[RD_LAT-1];

`ifdef ACC_RD_CLEAR_EN
   assign clr_en = rd_en;
`endif

endmodule

// File: tb/tb_acc_rd_ctrl.sv
// Directed testbench for acc_rd_ctrl (default parameters, RD_LAT = 1).
module tb_acc_rd_ctrl;

   logic          clk;
   logic          rst;
   logic          start;
   logic          mode;
   logic [6:0]    base_addr;
   logic [7:0]    num_rows;
   logic          out_ready;
   logic [31:0]   rd_en;
   logic [223:0]  rd_addr;
   logic          out_valid;
   logic [31:0]   out_bank_mask;
   logic          busy;
   logic          done;
`ifdef ACC_RD_CLEAR_EN
   logic [31:0]   clr_en;
`endif

   int vectors     = 0;
   int miscompares = 0;

   acc_rd_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .mode          (mode),
      .base_addr     (base_addr),
      .num_rows      (num_rows),
      .out_ready     (out_ready),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .out_valid     (out_valid),
      .out_bank_mask (out_bank_mask),
      .busy          (busy),
`ifdef ACC_RD_CLEAR_EN
      .clr_en        (clr_en),
`endif
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; num_rows = '0; out_ready = 1'b1;
      tick(); tick();
      vectors++;
      if ({rd_en, out_bank_mask, out_valid, busy, done} !== 67'd0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got en=%h mask=%h v=%b busy=%b done=%b, want all 0",
                  rd_en, out_bank_mask, out_valid, busy, done);
      end
      vectors++;
      if (rd_addr !== 224'd0) begin
         miscompares++;
         $display("FAIL reset_addr: got %h want 0", rd_addr);
      end
      rst = 1'b0;
      tick();
      vectors++;
      if ({rd_en, busy, done} !== 34'd0) begin
         miscompares++;
         $display("FAIL reset_idle: got en=%h busy=%b done=%b want 0", rd_en, busy, done);
      end
   endtask

   // NORMAL, base 5, N 3: cycle-accurate table after each edge.
   task automatic test_normal();
      logic [31:0]  exp_en  [7] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
      logic [6:0]   exp_a   [7] = '{7'd0, 7'd5, 7'd6, 7'd7, 7'd0, 7'd0, 7'd0};
      logic         exp_v   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic         exp_b   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic         exp_d   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [223:0] exp_addr;
      mode = 1'b0; base_addr = 7'd5; num_rows = 8'd3; out_ready = 1'b1; start = 1'b1;
      for (int c = 0; c < 7; c++) begin
         tick();
         start = 1'b0;
         exp_addr = {32{exp_a[c]}};
         vectors++;
         if (rd_en !== exp_en[c] || rd_addr !== exp_addr) begin
            miscompares++;
            $display("FAIL normal_issue c%0d: got en=%h a0=%0d want en=%h a=%0d",
                     c, rd_en, rd_addr[6:0], exp_en[c], exp_a[c]);
         end
         vectors++;
         if (out_valid !== exp_v[c] || out_bank_mask !== {32{exp_v[c]}}) begin
            miscompares++;
            $display("FAIL normal_valid c%0d: got v=%b mask=%h want v=%b", c, out_valid, out_bank_mask, exp_v[c]);
         end
         vectors++;
         if (busy !== exp_b[c] || done !== exp_d[c]) begin
            miscompares++;
            $display("FAIL normal_status c%0d: got busy=%b done=%b want busy=%b done=%b",
                     c, busy, done, exp_b[c], exp_d[c]);
         end
      end
   endtask

   task automatic test_diag();
      int issues = 0;
      int done_cyc = -1;
      int bad = 0;
      int bad_banks = 0;
      int cnt [32];
      logic [223:0] exp_addr;
      logic [31:0]  exp_en;
      logic [223:0] exp3;
      logic [223:0] exp34;
      exp3 = '0; exp3[6:0] = 7'd3; exp3[13:7] = 7'd2; exp3[20:14] = 7'd1;
      exp34 = '0; exp34[223:217] = 7'd3;
      for (int b = 0; b < 32; b++) cnt[b] = 0;
      mode = 1'b1; base_addr = 7'd0; num_rows = 8'd4; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         tick();
         if (done === 1'b1 && done_cyc < 0) done_cyc = c;
         if (rd_en !== 32'h0) begin
            exp_en = '0; exp_addr = '0;
            for (int b = 0; b < 32; b++) begin
               if (issues - b >= 0 && issues - b < 4) begin
                  exp_en[b] = 1'b1;
                  exp_addr[b*7 +: 7] = 7'(issues - b);
               end
               if (rd_en[b]) cnt[b]++;
            end
            if (rd_en !== exp_en || rd_addr !== exp_addr) bad++;
            if (issues == 0) begin
               vectors++;
               if (rd_en !== 32'h1 || rd_addr !== 224'd0) begin
                  miscompares++;
                  $display("FAIL diag_step0: got en=%h a0=%0d want en=1 a0=0", rd_en, rd_addr[6:0]);
               end
            end
            if (issues == 3) begin
               vectors++;
               if (rd_en !== 32'hF || rd_addr !== exp3) begin
                  miscompares++;
                  $display("FAIL diag_step3: got en=%h addr=%h want en=f addr=%h", rd_en, rd_addr, exp3);
               end
            end
            if (issues == 34) begin
               vectors++;
               if (rd_en !== 32'h80000000 || rd_addr !== exp34) begin
                  miscompares++;
                  $display("FAIL diag_step34: got en=%h a31=%0d want en=80000000 a31=3", rd_en, rd_addr[223:217]);
               end
            end
            issues++;
         end
      end
      for (int b = 0; b < 32; b++) if (cnt[b] != 4) bad_banks++;
      vectors++;
      if (issues != 35) begin
         miscompares++;
         $display("FAIL diag_issue_count: got %0d want 35", issues);
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL diag_pattern: got %0d wrong issue cycles want 0", bad);
      end
      vectors++;
      if (bad_banks != 0) begin
         miscompares++;
         $display("FAIL diag_bank_counts: got %0d banks not read 4 times want 0", bad_banks);
      end
      vectors++;
      if (done_cyc != 37) begin
         miscompares++;
         $display("FAIL diag_done_cycle: got %0d want 37", done_cyc);
      end
   endtask

   task automatic test_wrap();
      logic [6:0]   exp_a [4] = '{7'd126, 7'd127, 7'd0, 7'd1};
      logic [223:0] exp_addr;
      int issues = 0;
      mode = 1'b0; base_addr = 7'd126; num_rows = 8'd4; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (rd_en !== 32'h0) begin
            if (issues < 4) begin
               exp_addr = {32{exp_a[issues]}};
               vectors++;
               if (rd_en !== 32'hFFFFFFFF || rd_addr !== exp_addr) begin
                  miscompares++;
                  $display("FAIL wrap_addr i%0d: got en=%h a0=%0d a31=%0d want %0d",
                           issues, rd_en, rd_addr[6:0], rd_addr[223:217], exp_a[issues]);
               end
            end
            issues++;
         end
      end
      vectors++;
      if (issues != 4) begin
         miscompares++;
         $display("FAIL wrap_count: got %0d want 4", issues);
      end
   endtask

   task automatic test_stall();
      logic       exp_en [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [6:0] exp_a  [9] = '{7'd0, 7'd10, 7'd11, 7'd0, 7'd0, 7'd12, 7'd13, 7'd0, 7'd0};
      logic       exp_v  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic       exp_d  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [223:0] exp_addr;
      mode = 1'b0; base_addr = 7'd10; num_rows = 8'd4; out_ready = 1'b1; start = 1'b1;
      for (int c = 0; c < 9; c++) begin
         tick();
         start = 1'b0;
         out_ready = !(c == 2 || c == 3);
         exp_addr = {32{exp_a[c]}};
         vectors++;
         if (rd_en !== {32{exp_en[c]}} || rd_addr !== exp_addr) begin
            miscompares++;
            $display("FAIL stall_issue c%0d: got en=%h a0=%0d want en=%b a=%0d",
                     c, rd_en, rd_addr[6:0], exp_en[c], exp_a[c]);
         end
         vectors++;
         if (out_valid !== exp_v[c] || done !== exp_d[c]) begin
            miscompares++;
            $display("FAIL stall_out c%0d: got v=%b done=%b want v=%b done=%b",
                     c, out_valid, done, exp_v[c], exp_d[c]);
         end
      end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_zero_rows();
      logic exp_d [3] = '{1'b0, 1'b1, 1'b0};
      mode = 1'b0; base_addr = 7'd9; num_rows = 8'd0; start = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         start = 1'b0;
         vectors++;
         if (done !== exp_d[c] || rd_en !== 32'h0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_rows c%0d: got done=%b en=%h v=%b want done=%b en=0 v=0",
                     c, done, rd_en, out_valid, exp_d[c]);
         end
      end
   endtask

   // Start mid-sequence is ignored; a start coinciding with done is ignored.
   task automatic test_start_ignored();
      logic [31:0] exp_en [6] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
      logic [6:0]  exp_a  [6] = '{7'd0, 7'd20, 7'd21, 7'd0, 7'd0, 7'd0};
      logic        exp_d  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [223:0] exp_addr;
      mode = 1'b0; base_addr = 7'd20; num_rows = 8'd2; out_ready = 1'b1; start = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         start = 1'b0;
         if (c == 1) begin
            start = 1'b1; mode = 1'b1; base_addr = 7'd100; num_rows = 8'd5;
         end
         if (c == 4) begin
            start = 1'b1; mode = 1'b0; base_addr = 7'd50; num_rows = 8'd1;
         end
         exp_addr = {32{exp_a[c]}};
         vectors++;
         if (rd_en !== exp_en[c] || rd_addr !== exp_addr || done !== exp_d[c]) begin
            miscompares++;
            $display("FAIL ignore_start c%0d: got en=%h a0=%0d done=%b want en=%h a=%0d done=%b",
                     c, rd_en, rd_addr[6:0], done, exp_en[c], exp_a[c], exp_d[c]);
         end
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL ignore_done_start: got busy=%b want 0", busy);
      end
      tick();
      vectors++;
      if (rd_en !== 32'h0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL ignore_done_start2: got en=%h busy=%b want en=0 busy=0", rd_en, busy);
      end
   endtask

   // Start in the first IDLE cycle after done is accepted.
   task automatic test_back_to_back();
      mode = 1'b0; base_addr = 7'd40; num_rows = 8'd1; out_ready = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick();
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first_done: got %b want 1", done);
      end
      tick();
      base_addr = 7'd60; start = 1'b1;
      tick(); start = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_accept: got busy=%b want 1", busy);
      end
      tick();
      vectors++;
      if (rd_en !== 32'hFFFFFFFF || rd_addr[6:0] !== 7'd60) begin
         miscompares++;
         $display("FAIL b2b_issue: got en=%h a0=%0d want en=ffffffff a0=60", rd_en, rd_addr[6:0]);
      end
      tick(); tick(); tick();
   endtask

   task automatic test_reset_mid();
      int done_seen = 0;
      mode = 1'b1; base_addr = 7'd0; num_rows = 8'd4; out_ready = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      for (int c = 1; c <= 10; c++) tick();
      vectors++;
      if (rd_en !== 32'h000003C0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_pre: got en=%h busy=%b want en=000003c0 busy=1", rd_en, busy);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({rd_en, out_bank_mask, out_valid, busy, done} !== 67'd0 || rd_addr !== 224'd0) begin
         miscompares++;
         $display("FAIL rstmid_async: got en=%h mask=%h v=%b busy=%b done=%b want all 0",
                  rd_en, out_bank_mask, out_valid, busy, done);
      end
      tick(); tick();
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done === 1'b1 || rd_en !== 32'h0) done_seen++;
      end
      vectors++;
      if (done_seen != 0) begin
         miscompares++;
         $display("FAIL rstmid_quiet: got %0d active cycles want 0", done_seen);
      end
      mode = 1'b0; base_addr = 7'd1; num_rows = 8'd2; start = 1'b1;
      tick(); start = 1'b0;
      tick();
      vectors++;
      if (rd_en !== 32'hFFFFFFFF || rd_addr !== {32{7'd1}}) begin
         miscompares++;
         $display("FAIL rstmid_restart1: got en=%h a0=%0d want ffffffff/1", rd_en, rd_addr[6:0]);
      end
      tick();
      vectors++;
      if (rd_en !== 32'hFFFFFFFF || rd_addr !== {32{7'd2}}) begin
         miscompares++;
         $display("FAIL rstmid_restart2: got en=%h a0=%0d want ffffffff/2", rd_en, rd_addr[6:0]);
      end
      tick(); tick();
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_restart_done: got %b want 1", done);
      end
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; num_rows = '0; out_ready = 1'b1;
      test_reset();
      test_normal();
      test_diag();
      tick();
      test_wrap();
      tick();
      test_stall();
      test_zero_rows();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/acc_rd_ctrl.md
Name: acc_rd_ctrl

Overview:
Sequences reads of the 32-bank accumulator memory (128 entries per bank) after a matrix tile completes. It supports two modes. NORMAL reads the same row in every bank. DIAG applies a per-bank skew of base+r−b so the systolic array's diagonal output wavefront is de-skewed into aligned result rows. It sits between the tile controller and the accumulator banks, and produces a valid strobe aligned to the bank read data.

Parameters:
NUM_BANKS, 32, accumulator banks / array columns
ACC_AW, 7, bank address width (depth 128)
RD_LAT, 1, bank read latency in cycles (1..4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to begin a read sequence; ignored while busy
mode  in  1  acc_rd_mode: NORMAL=0, DIAG=1; sampled at accepted start
base_addr  in  ACC_AW  first row address; sampled at start
num_rows  in  ACC_AW+1  rows to read, 0..128; sampled at start
out_ready  in  1  downstream can take a new row; low stalls issue
rd_en  out  NUM_BANKS  per-bank read enable
rd_addr  out  NUM_BANKS*ACC_AW  per-bank address; bank b at bits [b*ACC_AW +: ACC_AW]
out_valid  out  1  bank read data valid; rd_en-issue delayed by RD_LAT
out_bank_mask  out  NUM_BANKS  which banks' data are valid with out_valid
busy  out  1  sequence in progress
done  out  1  one-cycle pulse once the last read data has been presented

Behaviour:
- Reset: state IDLE; rd_en=0, rd_addr=0, out_valid=0, out_bank_mask=0, busy=0, done=0; the counter and latency pipe are cleared.
- FSM states:
  - IDLE: on start, latch mode, base and N. If N==0, go to DONE with no reads. Otherwise go to ISSUE, with busy=1 from the next cycle.
  - ISSUE: step counter r runs from 0 to LAST, where LAST=N−1 for NORMAL and N+NUM_BANKS−2 for DIAG. In each cycle with out_ready=1, issue step r and then r++. When out_ready=0, rd_en=0 and r holds. After issuing LAST, go to DRAIN.
  - DRAIN: wait RD_LAT cycles for in-flight data, then go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- Issue, NORMAL: every bank has rd_en=1 and address (base+r) mod 128.
- Issue, DIAG: for each bank b, let k=r−b. rd_en[b]=1 only when 0≤k<N; then the address is (base+k) mod 128, otherwise 0.
- rd_en/rd_addr are registered and take effect the cycle after the step is chosen. out_valid and out_bank_mask equal the rd_en pipe delayed RD_LAT cycles (out_valid = OR of mask).
- Stalls do not stop in-flight data: up to RD_LAT rows may emerge after out_ready falls, and downstream must absorb them.
- Address wrap: base+k wraps modulo 128; no error is flagged.
- start while busy is ignored, with no effect on the current sequence.
- Reset mid-sequence aborts immediately and asynchronously to the reset state. No done pulse.
- A start that arrives in the same cycle as done is ignored. The next accepted start can be in the first IDLE cycle.

Optional Feature:
ACC_RD_CLEAR_EN
- Defined: adds output clr_en [NUM_BANKS]. clr_en equals rd_en in the same cycle at the same address, and banks are read-first, so each read also zeroes its entry for the next tile.
- Undefined: no clr_en port; reads are non-destructive.

Decomposition:
- Package tpu_package gains localparams NUM_BANKS=32, ACC_DEPTH=128 and ACC_AW=7.
- Reuse acc_rd_mode and diag_addr_array_t (per-bank address array) from the package.
- Sub-module acc_rd_addr_gen, purely combinational: inputs mode, base, N, r; outputs the per-bank enable vector and a diag_addr_array_t.
- acc_rd_ctrl holds the FSM, counter and latency pipe.

Test Plan:
- NORMAL, base=5, N=3, out_ready=1, RD_LAT=1:
  - rd_en=all-ones for 3 cycles with addresses 5, 6, 7 in all banks.
  - out_valid high 3 cycles, one cycle later.
  - done pulses one cycle after the last out_valid.
- DIAG, base=0, N=4:
  - 35 issue cycles.
  - Step 0: only bank 0, addr 0.
  - Step 3: banks 0..3 at addresses 3, 2, 1, 0.
  - Step 34: only bank 31, addr 3.
  - Each bank enabled exactly 4 times.
- Wrap, NORMAL, base=126, N=4 -> addresses 126, 127, 0, 1.
- Stall: N=4, out_ready low for 2 cycles after the second issue -> rd_en=0 for those 2 cycles, counter holds, sequence completes with 4 issues and 2 extra cycles.
- N=0 -> no rd_en; done pulses 2 cycles after start. A start pulsed mid-sequence is ignored.
- rst asserted mid-DIAG sequence -> all outputs 0 immediately, no done. A new start afterwards runs normally.
